sram_bus_arbiter: RTL and testbench

- Shares one SRAM-like memory port between the instruction-fetch requester (IF) and the data requester (EXE load/store).
- Arbitrates request phase (req/addr_ok) with data priority.
- Tracks outstanding accepted transactions in issue order and routes each data_ok/rdata back to its owner.
- Sits between the pipeline stages and the bus bridge in the CPU top.

---
 rtl/sram_bus_arbiter_pkg.sv | 13 +
 rtl/sram_bus_arbiter_owner_fifo.sv | 59 +++++
 rtl/sram_bus_arbiter.sv | 137 +++++++++++++
 tb/tb_sram_bus_arbiter.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_bus_arbiter_pkg.sv
// Shared encodings for the SRAM bus arbiter: transaction owner tags and access sizes.
package sram_bus_arbiter_pkg;

    typedef enum logic {
        OWNER_INST = 1'b0,
        OWNER_DATA = 1'b1
    } owner_e;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

endpackage

// File: rtl/sram_bus_arbiter_owner_fifo.sv
// In-order record of which requester owns each accepted-but-unreturned bus transaction.
module sram_bus_arbiter_owner_fifo
    import sram_bus_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  owner_e           din,
    input  logic             pop,
    output owner_e           head,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [CNT_W-1:0] count_q;
    owner_e           mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem_q[rd_ptr_q];
    assign count   = count_q;

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= OWNER_INST;
            end
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= din;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + CNT_W'(1);
            end else if (!do_push && do_pop) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/sram_bus_arbiter.sv
// Shares one SRAM-like bus between instruction fetch and data access, data first,
// and steers in-order responses back to whichever side issued each request.
module sram_bus_arbiter
    import sram_bus_arbiter_pkg::*;
#(
    parameter int unsigned OUTS_DEPTH = 4,
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              inst_req,
    input  logic              inst_wr,
    input  logic [1:0]        inst_size,
    input  logic [3:0]        inst_wstrb,
    input  logic [ADDR_W-1:0] inst_addr,
    input  logic [DATA_W-1:0] inst_wdata,
    output logic              inst_addr_ok,
    output logic              inst_data_ok,
    output logic [DATA_W-1:0] inst_rdata,

    input  logic              data_req,
    input  logic              data_wr,
    input  logic [1:0]        data_size,
    input  logic [3:0]        data_wstrb,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic              data_addr_ok,
    output logic              data_data_ok,
    output logic [DATA_W-1:0] data_rdata,

    output logic              req,
    output logic              wr,
    output logic [1:0]        size,
    output logic [3:0]        wstrb,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] wdata,
    input  logic              addr_ok,
    input  logic              data_ok,
    input  logic [DATA_W-1:0] rdata,

    output logic              spurious_err
);

    localparam int unsigned CNT_W = $clog2(OUTS_DEPTH) + 1;

    logic             lock_q;
    owner_e           lock_owner_q;
    logic             spurious_q;

    logic             grant_valid;
    owner_e           grant_owner;
    logic             owner_req;
    logic             sel_inst;
    logic             accept;
    logic             pop;

    owner_e           fifo_head;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_full;
    logic             fifo_empty;

    // A locked request holds the grant until accepted, so data cannot preempt it.
    always_comb begin
        grant_valid = 1'b0;
        grant_owner = OWNER_DATA;
        if (lock_q) begin
            grant_valid = 1'b1;
            grant_owner = lock_owner_q;
        end else if (data_req) begin
            grant_valid = 1'b1;
            grant_owner = OWNER_DATA;
        end else if (inst_req) begin
            grant_valid = 1'b1;
            grant_owner = OWNER_INST;
        end
        if (fifo_full) begin
            grant_valid = 1'b0;
        end
    end

    assign owner_req = (grant_owner == OWNER_DATA) ? data_req : inst_req;
    // Bus stays quiet while held in reset even if requesters are already active.
    assign req       = reset && grant_valid && owner_req;
    assign sel_inst  = grant_valid && (grant_owner == OWNER_INST);

    assign wr    = sel_inst ? inst_wr    : data_wr;
    assign size  = sel_inst ? inst_size  : data_size;
    assign wstrb = sel_inst ? inst_wstrb : data_wstrb;
    assign addr  = sel_inst ? inst_addr  : data_addr;
    assign wdata = sel_inst ? inst_wdata : data_wdata;

    assign accept       = req && addr_ok;
    assign inst_addr_ok = accept && sel_inst;
    assign data_addr_ok = accept && !sel_inst;

    assign pop          = data_ok && !fifo_empty;
    assign inst_data_ok = pop && (fifo_head == OWNER_INST);
    assign data_data_ok = pop && (fifo_head == OWNER_DATA);
    assign inst_rdata   = rdata;
    assign data_rdata   = rdata;
    assign spurious_err = spurious_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lock_q       <= 1'b0;
            lock_owner_q <= OWNER_DATA;
            spurious_q   <= 1'b0;
        end else begin
            if (req && !addr_ok) begin
                lock_q       <= 1'b1;
                lock_owner_q <= grant_owner;
            end else if (lock_q && (accept || !owner_req)) begin
                lock_q <= 1'b0;
            end
            if (data_ok && (fifo_count == '0)) begin
                spurious_q <= 1'b1;
            end
        end
    end

    sram_bus_arbiter_owner_fifo #(
        .DEPTH (OUTS_DEPTH)
    ) u_owner_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (accept),
        .din   (grant_owner),
        .pop   (pop),
        .head  (fifo_head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Directed bench for sram_bus_arbiter: arbitration, lock, ordering, full, spurious, reset.
module tb_sram_bus_arbiter;

    logic        clk;
    logic        reset;
    logic        inst_req, inst_wr;
    logic [1:0]  inst_size;
    logic [3:0]  inst_wstrb;
    logic [31:0] inst_addr, inst_wdata;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr, data_wdata;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic        req, wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr, wdata;
    logic        addr_ok, data_ok;
    logic [31:0] rdata;
    logic        spurious_err;

    int checks;
    int failures;

    sram_bus_arbiter #(
        .OUTS_DEPTH (4),
        .ADDR_W     (32),
        .DATA_W     (32)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .inst_req     (inst_req),
        .inst_wr      (inst_wr),
        .inst_size    (inst_size),
        .inst_wstrb   (inst_wstrb),
        .inst_addr    (inst_addr),
        .inst_wdata   (inst_wdata),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_wstrb   (data_wstrb),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata),
        .req          (req),
        .wr           (wr),
        .size         (size),
        .wstrb        (wstrb),
        .addr         (addr),
        .wdata        (wdata),
        .addr_ok      (addr_ok),
        .data_ok      (data_ok),
        .rdata        (rdata),
        .spurious_err (spurious_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge; inputs change here.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_bus();
        inst_req = 1'b0;
        data_req = 1'b0;
        addr_ok  = 1'b0;
        data_ok  = 1'b0;
        rdata    = 32'h0;
    endtask

    task automatic test_reset();
        reset      = 1'b0;
        inst_wr    = 1'b0;
        inst_size  = 2'd2;
        inst_wstrb = 4'b1111;
        inst_addr  = 32'h1c00_0000;
        inst_wdata = 32'h0;
        data_wr    = 1'b1;
        data_size  = 2'd0;
        data_wstrb = 4'b0001;
        data_addr  = 32'h1c00_0100;
        data_wdata = 32'hdddd_0000;
        clear_bus();
        data_req = 1'b1;
        addr_ok  = 1'b1;
        data_ok  = 1'b1;
        #2;
        checks++; if (req !== 1'b0) begin failures++; $display("FAIL rst_req got=%b exp=0", req); end
        checks++; if (data_addr_ok !== 1'b0) begin failures++; $display("FAIL rst_data_addr_ok got=%b exp=0", data_addr_ok); end
        checks++; if (inst_data_ok !== 1'b0 || data_data_ok !== 1'b0) begin failures++; $display("FAIL rst_data_ok got=%b%b exp=00", inst_data_ok, data_data_ok); end
        checks++; if (spurious_err !== 1'b0) begin failures++; $display("FAIL rst_spurious got=%b exp=0", spurious_err); end
        clear_bus();
        cyc();
        cyc();
        reset = 1'b1;
    endtask

    task automatic test_simultaneous();
        cyc();
        data_req = 1'b1; inst_req = 1'b1; addr_ok = 1'b1;
        #2;
        checks++; if (req !== 1'b1) begin failures++; $display("FAIL sim_req got=%b exp=1", req); end
        checks++; if (addr !== 32'h1c00_0100) begin failures++; $display("FAIL sim_addr got=%h exp=1c000100", addr); end
        checks++; if (data_addr_ok !== 1'b1 || inst_addr_ok !== 1'b0) begin failures++; $display("FAIL sim_addr_ok got=d%b i%b exp=d1 i0", data_addr_ok, inst_addr_ok); end
        checks++; if (wr !== 1'b1 || size !== 2'd0 || wstrb !== 4'b0001 || wdata !== 32'hdddd_0000) begin failures++; $display("FAIL sim_fields got=%b %0d %b %h exp=1 0 0001 dddd0000", wr, size, wstrb, wdata); end
        cyc();
        data_req = 1'b0;
        #2;
        checks++; if (addr !== 32'h1c00_0000 || inst_addr_ok !== 1'b1 || data_addr_ok !== 1'b0) begin failures++; $display("FAIL sim_inst_grant got=%h i%b d%b exp=1c000000 i1 d0", addr, inst_addr_ok, data_addr_ok); end
        checks++; if (wr !== 1'b0 || size !== 2'd2 || wstrb !== 4'b1111 || wdata !== 32'h0) begin failures++; $display("FAIL sim_inst_fields got=%b %0d %b %h exp=0 2 1111 0", wr, size, wstrb, wdata); end
        cyc();
        inst_req = 1'b0; addr_ok = 1'b0; data_ok = 1'b1; rdata = 32'haa;
        #2;
        checks++; if (data_data_ok !== 1'b1 || inst_data_ok !== 1'b0 || data_rdata !== 32'haa) begin failures++; $display("FAIL sim_resp0 got=d%b i%b %h exp=d1 i0 aa", data_data_ok, inst_data_ok, data_rdata); end
        cyc();
        rdata = 32'hbb;
        #2;
        checks++; if (inst_data_ok !== 1'b1 || data_data_ok !== 1'b0 || inst_rdata !== 32'hbb) begin failures++; $display("FAIL sim_resp1 got=i%b d%b %h exp=i1 d0 bb", inst_data_ok, data_data_ok, inst_rdata); end
        cyc();
        clear_bus();
    endtask

    task automatic test_lock_hold();
        inst_req = 1'b1; addr_ok = 1'b0;
        #2;
        checks++; if (req !== 1'b1 || addr !== 32'h1c00_0000 || inst_addr_ok !== 1'b0) begin failures++; $display("FAIL lock_c1 got=%b %h %b exp=1 1c000000 0", req, addr, inst_addr_ok); end
        cyc();
        data_req = 1'b1;
        #2;
        checks++; if (req !== 1'b1 || addr !== 32'h1c00_0000) begin failures++; $display("FAIL lock_c2 got=%b %h exp=1 1c000000", req, addr); end
        cyc();
        #2;
        checks++; if (addr !== 32'h1c00_0000 || data_addr_ok !== 1'b0) begin failures++; $display("FAIL lock_c3 got=%h %b exp=1c000000 0", addr, data_addr_ok); end
        cyc();
        addr_ok = 1'b1;
        #2;
        checks++; if (inst_addr_ok !== 1'b1 || data_addr_ok !== 1'b0 || addr !== 32'h1c00_0000) begin failures++; $display("FAIL lock_accept got=i%b d%b %h exp=i1 d0 1c000000", inst_addr_ok, data_addr_ok, addr); end
        cyc();
        #2;
        checks++; if (data_addr_ok !== 1'b1 || addr !== 32'h1c00_0100) begin failures++; $display("FAIL lock_release got=%b %h exp=1 1c000100", data_addr_ok, addr); end
        cyc();
        clear_bus();
        data_ok = 1'b1;
        #2;
        checks++; if (inst_data_ok !== 1'b1 || data_data_ok !== 1'b0) begin failures++; $display("FAIL lock_resp0 got=i%b d%b exp=i1 d0", inst_data_ok, data_data_ok); end
        cyc();
        #2;
        checks++; if (data_data_ok !== 1'b1 || inst_data_ok !== 1'b0) begin failures++; $display("FAIL lock_resp1 got=i%b d%b exp=i0 d1", inst_data_ok, data_data_ok); end
        cyc();
        clear_bus();
    endtask

    task automatic test_ordering();
        logic [2:0]  exp_inst;
        logic [31:0] vals [3];
        exp_inst = 3'b101;
        vals[0] = 32'h11; vals[1] = 32'h22; vals[2] = 32'h33;
        addr_ok = 1'b1;
        for (int i = 0; i < 3; i++) begin
            inst_req = exp_inst[i];
            data_req = !exp_inst[i];
            #2;
            checks++; if (inst_addr_ok !== exp_inst[i] || data_addr_ok !== !exp_inst[i]) begin failures++; $display("FAIL ord_accept%0d got=i%b d%b exp=i%b", i, inst_addr_ok, data_addr_ok, exp_inst[i]); end
            cyc();
        end
        clear_bus();
        data_ok = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rdata = vals[i];
            #2;
            checks++; if (inst_data_ok !== exp_inst[i] || data_data_ok !== !exp_inst[i] || inst_rdata !== vals[i] || data_rdata !== vals[i]) begin failures++; $display("FAIL ord_resp%0d got=i%b d%b %h exp=i%b %h", i, inst_data_ok, data_data_ok, inst_rdata, exp_inst[i], vals[i]); end
            cyc();
        end
        clear_bus();
    endtask

    task automatic test_full();
        data_req = 1'b1; addr_ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #2;
            checks++; if (data_addr_ok !== 1'b1) begin failures++; $display("FAIL full_fill%0d got=%b exp=1", i, data_addr_ok); end
            cyc();
        end
        #2;
        checks++; if (req !== 1'b0 || data_addr_ok !== 1'b0) begin failures++; $display("FAIL full_block got=%b %b exp=0 0", req, data_addr_ok); end
        cyc();
        data_ok = 1'b1;
        #2;
        checks++; if (req !== 1'b0 || data_data_ok !== 1'b1) begin failures++; $display("FAIL full_pop_block got=req%b dok%b exp=req0 dok1", req, data_data_ok); end
        cyc();
        data_ok = 1'b0;
        #2;
        checks++; if (req !== 1'b1 || data_addr_ok !== 1'b1) begin failures++; $display("FAIL full_reassert got=%b %b exp=1 1", req, data_addr_ok); end
        cyc();
        clear_bus();
        data_ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #2;
            checks++; if (data_data_ok !== 1'b1 || inst_data_ok !== 1'b0) begin failures++; $display("FAIL full_drain%0d got=d%b i%b exp=d1 i0", i, data_data_ok, inst_data_ok); end
            cyc();
        end
        clear_bus();
    endtask

    task automatic test_push_pop();
        inst_req = 1'b1; addr_ok = 1'b1;
        cyc();
        inst_req = 1'b0; data_req = 1'b1;
        cyc();
        data_ok = 1'b1;
        #2;
        checks++; if (inst_data_ok !== 1'b1 || data_data_ok !== 1'b0 || data_addr_ok !== 1'b1) begin failures++; $display("FAIL pp_same got=i%b d%b a%b exp=i1 d0 a1", inst_data_ok, data_data_ok, data_addr_ok); end
        cyc();
        data_ok = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #2;
            checks++; if (req !== (i < 2)) begin failures++; $display("FAIL pp_count%0d got=%b exp=%b", i, req, (i < 2)); end
            cyc();
        end
        clear_bus();
        data_ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #2;
            checks++; if (data_data_ok !== 1'b1 || inst_data_ok !== 1'b0) begin failures++; $display("FAIL pp_drain%0d got=d%b i%b exp=d1 i0", i, data_data_ok, inst_data_ok); end
            cyc();
        end
        clear_bus();
    endtask

    task automatic test_spurious_reset();
        data_ok = 1'b1;
        #2;
        checks++; if (inst_data_ok !== 1'b0 || data_data_ok !== 1'b0) begin failures++; $display("FAIL spur_no_ok got=i%b d%b exp=0 0", inst_data_ok, data_data_ok); end
        cyc();
        data_ok = 1'b0;
        #2;
        checks++; if (spurious_err !== 1'b1) begin failures++; $display("FAIL spur_set got=%b exp=1", spurious_err); end
        inst_req = 1'b1; addr_ok = 1'b1;
        for (int i = 0; i < 3; i++) cyc();
        inst_req = 1'b0; addr_ok = 1'b0;
        #2;
        checks++; if (spurious_err !== 1'b1) begin failures++; $display("FAIL spur_sticky got=%b exp=1", spurious_err); end
        cyc();
        data_req = 1'b1;
        #2;
        checks++; if (req !== 1'b1) begin failures++; $display("FAIL rst_pre_req got=%b exp=1", req); end
        reset = 1'b0;
        #1;
        checks++; if (req !== 1'b0 || spurious_err !== 1'b0 || data_addr_ok !== 1'b0) begin failures++; $display("FAIL rst_async got=req%b err%b aok%b exp=0 0 0", req, spurious_err, data_addr_ok); end
        cyc();
        reset = 1'b1;
        data_req = 1'b0;
        data_ok = 1'b1;
        #2;
        checks++; if (inst_data_ok !== 1'b0 || data_data_ok !== 1'b0) begin failures++; $display("FAIL rst_count_zero got=i%b d%b exp=0 0", inst_data_ok, data_data_ok); end
        cyc();
        data_ok = 1'b0;
        #2;
        checks++; if (spurious_err !== 1'b1) begin failures++; $display("FAIL rst_spur_again got=%b exp=1", spurious_err); end
        clear_bus();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_simultaneous();
        test_lock_hold();
        test_ordering();
        test_full();
        test_push_pop();
        test_spurious_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
